flash_read_ctrl: RTL and testbench



---
 rtl/flash_pkg.sv | 24 ++
 rtl/flash_spi_bit_engine.sv | 65 ++++++
 rtl/flash_read_ctrl.sv | 167 ++++++++++++++++
 tb/tb_flash_read_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash controllers (read, sector erase, page program).
// Holds instruction opcodes, default address bytes, slot timing and FSM encodings.
package flash_pkg;

  localparam logic [7:0] INST_READ  = 8'h03;
  localparam logic [7:0] INST_WR_EN = 8'h06;
  localparam logic [7:0] INST_SE    = 8'hD8;

  localparam logic [7:0] DEF_S_ADDR = 8'h00;
  localparam logic [7:0] DEF_P_ADDR = 8'h04;
  localparam logic [7:0] DEF_B_ADDR = 8'h25;

  localparam int CLK_PER_BYTE = 32;
  localparam int CNT_CLK_W    = 5;
  localparam int CNT_BYTE_W   = 9;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_CMD  = 4'b0010,
    ST_DATA = 4'b0100,
    ST_END  = 4'b1000
  } state_e;

endpackage

// File: rtl/flash_spi_bit_engine.sv
// SPI mode-0 bit engine: derives sck, mosi and the receive shifter from a 32-cycle slot counter.
// The slot counter and framing are owned by the instantiating controller.
module flash_spi_bit_engine
  import flash_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_CLK_W-1:0] cnt_clk,
  input  logic                 tx_en,
  input  logic                 rx_en,
  input  logic [7:0]           tx_byte,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic [7:0]           rx_byte
);

  logic [1:0] cnt_sck_s;
  logic [2:0] cnt_bit_s;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] shift_q, shift_d;

  assign cnt_sck_s = cnt_clk[1:0];
  assign cnt_bit_s = cnt_clk[4:2];

  // Next sck/mosi/shifter values; mosi changes a full cycle before the sck rise.
  always_comb begin
    sck_d   = (tx_en || rx_en) && ((cnt_sck_s == 2'd1) || (cnt_sck_s == 2'd2));
    mosi_d  = mosi_q;
    shift_d = shift_q;
    if (tx_en) begin
      if (cnt_sck_s == 2'd0) begin
        mosi_d = tx_byte[3'd7 - cnt_bit_s];
      end else begin
        mosi_d = mosi_q;
      end
    end else begin
      mosi_d = 1'b0;
    end
    if (rx_en && (cnt_sck_s == 2'd2)) begin
      shift_d = {shift_q[6:0], miso};
    end else begin
      shift_d = shift_q;
    end
  end

  // Bit-engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      shift_q <= 8'h00;
    end else begin
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      shift_q <= shift_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign rx_byte = shift_q;

endmodule

// File: rtl/flash_read_ctrl.sv
// Read Data (0x03) initiator: instruction + 24-bit address, then NUM_DATA bytes from miso,
// each presented on rx_data with a one-cycle rx_valid strobe.
module flash_read_ctrl
  import flash_pkg::*;
#(
  parameter logic [7:0] READ_INST = INST_READ,
  parameter logic [7:0] S_ADDR    = DEF_S_ADDR,
  parameter logic [7:0] P_ADDR    = DEF_P_ADDR,
  parameter logic [7:0] B_ADDR    = DEF_B_ADDR,
  parameter int         NUM_DATA  = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  input  logic       miso,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam logic [CNT_BYTE_W-1:0] LAST_CMD_BYTE = 9'd3;
  localparam logic [CNT_BYTE_W-1:0] LAST_BYTE     = CNT_BYTE_W'(NUM_DATA - 1);
  localparam logic [CNT_CLK_W-1:0]  SLOT_END      = CNT_CLK_W'(CLK_PER_BYTE - 1);

  state_e                  state_q, state_d;
  logic [CNT_CLK_W-1:0]    cnt_clk_q, cnt_clk_d;
  logic [CNT_BYTE_W-1:0]   cnt_byte_q, cnt_byte_d;
  logic                    cs_n_q, cs_n_d;
  logic                    busy_q, busy_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic [7:0]              tx_byte_s, rx_byte_s;
  logic                    slot_end_s, tx_en_s, rx_en_s;

  assign slot_end_s = (cnt_clk_q == SLOT_END);
  assign tx_en_s    = (state_q == ST_CMD);
  assign rx_en_s    = (state_q == ST_DATA);

  // Command byte for the current CMD slot.
  always_comb begin
    case (cnt_byte_q[1:0])
      2'd0:    tx_byte_s = READ_INST;
      2'd1:    tx_byte_s = S_ADDR;
      2'd2:    tx_byte_s = P_ADDR;
      2'd3:    tx_byte_s = B_ADDR;
      default: tx_byte_s = READ_INST;
    endcase
  end

  // FSM next state, slot/byte counters and the byte output strobe.
  always_comb begin
    state_d    = state_q;
    cnt_clk_d  = cnt_clk_q;
    cnt_byte_d = cnt_byte_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    if (state_q != ST_IDLE) begin
      cnt_clk_d = cnt_clk_q + 5'd1;
      if (slot_end_s) begin
        cnt_byte_d = cnt_byte_q + 9'd1;
      end else begin
        cnt_byte_d = cnt_byte_q;
      end
    end else begin
      cnt_clk_d  = 5'd0;
      cnt_byte_d = 9'd0;
    end
    case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d    = ST_CMD;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_clk_d  = 5'd0;
          cnt_byte_d = 9'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (slot_end_s && (cnt_byte_q == LAST_CMD_BYTE)) begin
          state_d    = ST_DATA;
          cnt_byte_d = 9'd0;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (slot_end_s) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_byte_s;
        end else begin
          rx_valid_d = 1'b0;
        end
        if (slot_end_s && (cnt_byte_q == LAST_BYTE)) begin
          state_d    = ST_END;
          cnt_byte_d = 9'd0;
          cs_n_d     = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_END: begin
        // Full 32-cycle deselect keeps cs_n high well beyond tSHSL.
        if (slot_end_s) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          cnt_byte_d = 9'd0;
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cs_n_d     = 1'b1;
        busy_d     = 1'b0;
        cnt_clk_d  = 5'd0;
        cnt_byte_d = 9'd0;
      end
    endcase
  end

  // Controller registers; reset deselects the flash immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_clk_q  <= 5'd0;
      cnt_byte_q <= 9'd0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_clk_q  <= cnt_clk_d;
      cnt_byte_q <= cnt_byte_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  flash_spi_bit_engine u_bit_engine (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .cnt_clk (cnt_clk_q),
    .tx_en   (tx_en_s),
    .rx_en   (rx_en_s),
    .tx_byte (tx_byte_s),
    .miso    (miso),
    .sck     (sck),
    .mosi    (mosi),
    .rx_byte (rx_byte_s)
  );

  assign cs_n     = cs_n_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: three instances (NUM_DATA 4, 1, 256) each attached to a
// behavioural SPI flash that decodes the command on sck rises and serves random memory bytes.
module tb_flash_read_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] keys = 3'b000;
  logic [2:0] misos = 3'b000;
  logic [2:0] sck_w, csn_w, mosi_w, rxv_w, busy_w;
  logic [7:0] rxd [3];

  int n_tests = 0;
  int n_fail  = 0;

  int          nd [3]        = '{4, 1, 256};
  logic [7:0]  mem [3][256];
  int          cyc           = 0;
  logic [31:0] cmdw [3]      = '{32'd0, 32'd0, 32'd0};
  int          bitcnt [3]    = '{0, 0, 0};
  int          ob [3]        = '{0, 0, 0};
  int          rises [3]     = '{0, 0, 0};
  int          last_rise [3] = '{0, 0, 0};
  int          lowcnt [3]    = '{0, 0, 0};
  int          pulses [3]    = '{0, 0, 0};
  int          last_val [3]  = '{0, 0, 0};
  logic        sck_prev [3]  = '{1'b0, 1'b0, 1'b0};
  logic        mosi_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic        cs_prev [3]   = '{1'b1, 1'b1, 1'b1};

  always #5 sys_clk = ~sys_clk;

  flash_read_ctrl #(.NUM_DATA(4)) u_n4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(keys[0]), .miso(misos[0]),
    .sck(sck_w[0]), .cs_n(csn_w[0]), .mosi(mosi_w[0]), .rx_data(rxd[0]),
    .rx_valid(rxv_w[0]), .busy(busy_w[0]));

  flash_read_ctrl #(.NUM_DATA(1)) u_n1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(keys[1]), .miso(misos[1]),
    .sck(sck_w[1]), .cs_n(csn_w[1]), .mosi(mosi_w[1]), .rx_data(rxd[1]),
    .rx_valid(rxv_w[1]), .busy(busy_w[1]));

  flash_read_ctrl #(.NUM_DATA(256)) u_n256 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(keys[2]), .miso(misos[2]),
    .sck(sck_w[2]), .cs_n(csn_w[2]), .mosi(mosi_w[2]), .rx_data(rxd[2]),
    .rx_valid(rxv_w[2]), .busy(busy_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Flash model and scoreboard, sampled on the falling sys_clk edge.
  always @(negedge sys_clk) begin
    logic [7:0] b;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rxv_w[i]) begin
        chk("rx_count_in_range", {31'd0, pulses[i] < nd[i]}, 32'd1);
        if (pulses[i] < nd[i]) chk("rx_data", {24'd0, rxd[i]}, {24'd0, mem[i][pulses[i]]});
        if (pulses[i] > 0) chk("rx_gap", cyc - last_val[i], 32);
        last_val[i] = cyc;
        pulses[i]++;
      end
      if (csn_w[i]) begin
        chk("sck_mosi_deselected", {30'd0, sck_w[i], mosi_w[i]}, 32'd0);
        misos[i] = 1'b0;
      end else begin
        if (cs_prev[i]) begin
          lowcnt[i] = 0; rises[i] = 0; bitcnt[i] = 0; ob[i] = 0; cmdw[i] = 32'd0; pulses[i] = 0;
        end
        lowcnt[i]++;
        if (sck_w[i] && !sck_prev[i]) begin
          chk("mosi_setup", {31'd0, mosi_w[i]}, {31'd0, mosi_prev[i]});
          if (rises[i] > 0) chk("sck_period", cyc - last_rise[i], 4);
          if (bitcnt[i] < 32) begin
            cmdw[i] = {cmdw[i][30:0], mosi_w[i]};
            bitcnt[i]++;
          end
          last_rise[i] = cyc;
          rises[i]++;
        end
        if (!sck_w[i] && sck_prev[i]) begin
          chk("sck_high_time", cyc - last_rise[i], 2);
          if (bitcnt[i] == 32 && ob[i] < nd[i] * 8) begin
            b = mem[i][ob[i] / 8];
            misos[i] = b[7 - (ob[i] % 8)];
            ob[i]++;
          end
        end
      end
      sck_prev[i]  = sck_w[i];
      mosi_prev[i] = mosi_w[i];
      cs_prev[i]   = csn_w[i];
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Pulse key for one cycle; returns at the first negedge after the accepting edge.
  task automatic start_txn(input int i);
    keys[i] = 1'b1;
    @(negedge sys_clk);
    keys[i] = 1'b0;
    chk("start_cs_n", {31'd0, csn_w[i]}, 32'd0);
    chk("start_busy", {31'd0, busy_w[i]}, 32'd1);
  endtask

  task automatic wait_done(input int i, input int budget, output int k);
    k = 0;
    while (busy_w[i] && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    chk("done_within_budget", {31'd0, busy_w[i]}, 32'd0);
  endtask

  task automatic check_txn(input int i);
    chk("cmd_word", cmdw[i], 32'h0300_0425);
    chk("rx_pulses", pulses[i], nd[i]);
    chk("cs_low_cycles", lowcnt[i], (4 + nd[i]) * 32);
    chk("sck_rises", rises[i], (4 + nd[i]) * 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 256; j++) mem[i][j] = 8'($urandom);
    mem[0][0] = 8'hA5; mem[0][1] = 8'h3C; mem[0][2] = 8'hFF; mem[0][3] = 8'h00;

    // Reset, then 100 idle cycles.
    cycles(3);
    sys_rst_n = 1'b1;
    repeat (100) begin
      @(negedge sys_clk);
      for (int i = 0; i < 3; i++) begin
        chk("idle_outputs", {27'd0, sck_w[i], csn_w[i], mosi_w[i], rxv_w[i], busy_w[i]}, 32'h08);
        chk("idle_rx_data", {24'd0, rxd[i]}, 32'd0);
      end
    end

    // Transaction with ignored keys at 10, 150, during END and on the END->IDLE edge.
    start_txn(0);
    cycles(9);   keys[0] = 1'b1; cycles(1); keys[0] = 1'b0;
    cycles(139); keys[0] = 1'b1; cycles(1); keys[0] = 1'b0;
    cycles(119);
    chk("in_end_cs_n", {31'd0, csn_w[0]}, 32'd1);
    chk("in_end_busy", {31'd0, busy_w[0]}, 32'd1);
    keys[0] = 1'b1; cycles(1); keys[0] = 1'b0;
    cycles(17);
    chk("busy_last_cycle", {31'd0, busy_w[0]}, 32'd1);
    keys[0] = 1'b1; cycles(1); keys[0] = 1'b0;
    chk("busy_fall", {31'd0, busy_w[0]}, 32'd0);
    check_txn(0);
    cycles(1);
    chk("key_on_end_edge_ignored", {31'd0, csn_w[0]}, 32'd1);
    cycles(20);
    chk("still_idle", {30'd0, csn_w[0], busy_w[0]}, 32'h2);

    // Back-to-back: key in the first IDLE cycle is accepted.
    cycles($urandom_range(1, 20));
    start_txn(0);
    wait_done(0, 400, k);
    chk("busy_cycles_n4", k, 9 * 32);
    check_txn(0);
    start_txn(0);
    wait_done(0, 400, k);
    check_txn(0);

    // Reset midway through DATA byte 2.
    cycles($urandom_range(1, 20));
    start_txn(0);
    cycles(208);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, csn_w[0]}, 32'd1);
    chk("abort_sck", {31'd0, sck_w[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("abort_pulses", pulses[0], 2);
    cycles(5);
    sys_rst_n = 1'b1;
    cycles(40);
    chk("no_rx_after_abort", pulses[0], 2);
    chk("rx_data_after_abort", {24'd0, rxd[0]}, 32'd0);
    start_txn(0);
    wait_done(0, 400, k);
    check_txn(0);

    // NUM_DATA boundaries.
    cycles($urandom_range(1, 20));
    start_txn(1);
    wait_done(1, 400, k);
    chk("busy_cycles_n1", k, 6 * 32);
    check_txn(1);
    cycles($urandom_range(1, 20));
    start_txn(2);
    wait_done(2, 9000, k);
    chk("busy_cycles_n256", k, 261 * 32);
    check_txn(2);
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
